// File: rtl/seg_pkg.sv
// Shared types and segment table for the seven-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] hex;
        logic [7:0]  dp;
        logic        blz;
    } shadow_t;

    // Entry n holds the pattern for nibble n (entry 0 is the rightmost).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decode.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with blanking gaps,
// per-frame input shadowing and optional leading-zero suppression.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] HEX_IN,
    input  logic [7:0]  DP_IN,
    input  logic        BLANK_LZ,
    output logic [7:0]  ANODE,
    output logic [6:0]  CATHODE,
    output logic        DP,
    output logic        FRAME_DONE
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    dig_q, dig_d;
    shadow_t       sh_q, sh_d;
    logic [7:0]    anode_q, anode_d;
    logic [6:0]    cath_q, cath_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;

    logic [3:0]    nib;
    logic [6:0]    seg;
    logic [7:0]    lz;
    logic          hz;

    assign nib = sh_q.hex[{dig_q, 2'b00} +: 4];

    hex_to_seg u_dec (
        .nib_i (nib),
        .seg_o (seg)
    );

    // lz[k]: digit k and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        lz = '0;
        hz = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            hz    = hz & (sh_q.hex[4*k +: 4] == 4'h0);
            lz[k] = hz & sh_q.blz;
        end
    end

    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        bcnt_d  = bcnt_q;
        dig_d   = dig_q;
        sh_d    = sh_q;
        anode_d = 8'hFF;
        cath_d  = 7'h7F;
        dp_d    = 1'b1;
        fd_d    = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (dig_q == 3'd0 && bcnt_q == '0) begin
                    sh_d = '{hex: HEX_IN, dp: DP_IN, blz: BLANK_LZ};
                end
                if (bcnt_q == B_LAST) begin
                    bcnt_d  = '0;
                    state_d = ST_ON;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_ON: begin
                if (!lz[dig_q]) begin
                    anode_d[dig_q] = 1'b0;
                    cath_d         = seg;
                    dp_d           = ~sh_q.dp[dig_q];
                end
                if (ccnt_q == C_LAST) begin
                    ccnt_d  = '0;
                    state_d = ST_BLANK;
                    dig_d   = dig_q + 3'd1;
                    fd_d    = (dig_q == 3'd7);
                end else begin
                    ccnt_d = ccnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= ST_BLANK;
            ccnt_q  <= '0;
            bcnt_q  <= '0;
            dig_q   <= '0;
            sh_q    <= '0;
            anode_q <= 8'hFF;
            cath_q  <= 7'h7F;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            bcnt_q  <= bcnt_d;
            dig_q   <= dig_d;
            sh_q    <= sh_d;
            anode_q <= anode_d;
            cath_q  <= cath_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign ANODE      = anode_q;
    assign CATHODE    = cath_q;
    assign DP         = dp_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed frame-by-frame bench for seven_seg_scanner
// with CLK_DIV=4, BLANK_CYC=1 (40-cycle frame).
module tb_seven_seg_scanner;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [31:0] HEX_IN;
    logic [7:0]  DP_IN;
    logic        BLANK_LZ;
    logic [7:0]  ANODE;
    logic [6:0]  CATHODE;
    logic        DP;
    logic        FRAME_DONE;

    int nchk = 0;
    int nerr = 0;

    seven_seg_scanner #(
        .CLK_DIV   (4),
        .BLANK_CYC (1)
    ) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .HEX_IN     (HEX_IN),
        .DP_IN      (DP_IN),
        .BLANK_LZ   (BLANK_LZ),
        .ANODE      (ANODE),
        .CATHODE    (CATHODE),
        .DP         (DP),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " an"}, ANODE, 8'hFF);
        chk({nm, " ca"}, CATHODE, 7'h7F);
        chk({nm, " dp"}, DP, 1'b1);
        chk({nm, " fd"}, FRAME_DONE, 1'b0);
    endtask

    // Slot s of a frame: digit s/5; phase 0 is the blank cycle.
    task automatic run_frame(input string nm,
                             input logic [7:0][6:0] segs,
                             input logic [7:0] lit,
                             input logic [7:0] dpn,
                             input int chg_at,
                             input logic [31:0] chg_val,
                             input int rst_at);
        logic [7:0] one;
        logic [7:0] e_an;
        logic [6:0] e_ca;
        logic       e_dp;
        logic       on;
        int         d;
        one = 8'h01;
        for (int s = 0; s < 40; s++) begin
            tick;
            d    = s / 5;
            on   = (s % 5 != 0) && lit[d];
            e_an = on ? ~(one << d) : 8'hFF;
            e_ca = on ? segs[d] : 7'h7F;
            e_dp = on ? ~dpn[d] : 1'b1;
            chk($sformatf("%s s%0d an", nm, s), ANODE, e_an);
            chk($sformatf("%s s%0d ca", nm, s), CATHODE, e_ca);
            chk($sformatf("%s s%0d dp", nm, s), DP, e_dp);
            chk($sformatf("%s s%0d fd", nm, s), FRAME_DONE, s == 39);
            if (s == chg_at) HEX_IN = chg_val;
            if (s == rst_at) begin
                RESETn = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        RESETn   = 1'b0;
        HEX_IN   = 32'h12345678;
        DP_IN    = 8'h00;
        BLANK_LZ = 1'b0;
        tick;
        tick;
        chk_reset("rst");
        RESETn = 1'b1;

        run_frame("f1", {7'h79, 7'h24, 7'h30, 7'h19,
                         7'h12, 7'h02, 7'h78, 7'h00},
                  8'hFF, 8'h00, -1, 32'h0, -1);
        run_frame("f2", {7'h79, 7'h24, 7'h30, 7'h19,
                         7'h12, 7'h02, 7'h78, 7'h00},
                  8'hFF, 8'h00, -1, 32'h0, -1);

        HEX_IN = 32'hAAAAAAAA;
        run_frame("f3", {8{7'h08}}, 8'hFF, 8'h00,
                  17, 32'h55555555, -1);
        run_frame("f4", {8{7'h12}}, 8'hFF, 8'h00, -1, 32'h0, -1);

        BLANK_LZ = 1'b1;
        HEX_IN   = 32'h000000F0;
        run_frame("f5", {{6{7'h7F}}, 7'h0E, 7'h40},
                  8'h03, 8'h00, -1, 32'h0, -1);

        HEX_IN = 32'h0;
        DP_IN  = 8'hFF;
        run_frame("f6", {{7{7'h7F}}, 7'h40},
                  8'h01, 8'hFF, -1, 32'h0, -1);

        BLANK_LZ = 1'b0;
        DP_IN    = 8'h01;
        run_frame("f7", {8{7'h40}}, 8'hFF, 8'h01, -1, 32'h0, -1);
        run_frame("f8", {8{7'h40}}, 8'hFF, 8'h01, -1, 32'h0, 27);

        HEX_IN = 32'hFEDCBA90;
        DP_IN  = 8'h80;
        tick;
        chk_reset("midrst");
        RESETn = 1'b1;
        run_frame("f9", {7'h0E, 7'h06, 7'h21, 7'h46,
                         7'h03, 7'h08, 7'h10, 7'h40},
                  8'hFF, 8'h80, -1, 32'h0, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning CLK cycles each digit is lit (range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 1000, meaning all-anodes-off cycles before each digit (range 1..2^16).
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port RESETn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port HEX_IN  input  32  value to display; digit k shows HEX_IN[4k+3:4k]; driven from the system's SEVENSEGHEX register.
REQ-006 SHALL have port DP_IN  input  8  decimal point request per digit; bit k is digit k, active-high.
REQ-007 SHALL have port BLANK_LZ  input  1  enables leading-zero blanking when high.
REQ-008 SHALL have port ANODE  output  8  digit enables, active-low; bit k is digit k.
REQ-009 SHALL have port CATHODE  output  7  segments {g,f,e,d,c,b,a}, bit6..bit0, active-low.
REQ-010 SHALL have port DP  output  1  decimal-point segment, active-low.
REQ-011 SHALL have port FRAME_DONE  output  1  one-cycle pulse at the end of each 8-digit frame.

Function
REQ-012 SHALL use an FSM with states BLANK (ANODE=8'hFF, CATHODE=7'h7F, DP=1) and ON (ANODE bit for the current digit low, all others high).
REQ-013 SHALL stay in BLANK for exactly BLANK_CYC cycles, then enter ON for exactly CLK_DIV cycles, then return to BLANK for the next digit.
REQ-014 SHALL scan digits in the order 0,1,...,7, then wrap to 0; one frame lasts 8*(BLANK_CYC+CLK_DIV) cycles.
REQ-015 SHALL assert FRAME_DONE for one cycle, coincident with the last ON cycle of digit 7.
REQ-016 SHALL capture HEX_IN, DP_IN and BLANK_LZ into a shadow register on the first BLANK cycle of digit 0 only; mid-frame input changes SHALL NOT affect the current frame.
REQ-017 SHALL register all outputs; an output change SHALL appear one cycle after the state or counter change that causes it.
REQ-018 SHALL decode each nibble 0..F to CATHODE as 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-019 SHALL drive DP low during the ON state of digit k when shadow DP_IN[k]=1.
REQ-020 SHALL, when shadow BLANK_LZ=1, keep ANODE[k] high during ON for every digit k>0 whose nibble and all higher nibbles are zero. Digit 0 SHALL always display; a blanked digit SHALL also suppress DP.
REQ-021 SHALL use saturating-free wrap counters sized by $clog2 of each parameter; neither counter SHALL exceed its parameter minus 1.

Reset
REQ-022 SHALL, while RESETn=0 at a rising edge, set the FSM to BLANK, digit index to 0, both counters to 0, the shadow register to 0, ANODE=8'hFF, CATHODE=7'h7F, DP=1 and FRAME_DONE=0.
REQ-023 SHALL, when reset is asserted mid-ON, turn all anodes off on the next edge. After release, it SHALL restart at digit 0 BLANK and capture inputs on the first cycle after release.

Structure
REQ-024 SHALL take the FSM state enum and the 16-entry segment table from the shared package seg_pkg.
REQ-025 SHALL instantiate one combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out) for the decode.

Verification (CLK_DIV=4, BLANK_CYC=1, frame=40 cycles)
REQ-026 SHALL verify: reset, then HEX_IN=32'h12345678 -> digit0 ON shows CATHODE=7'h00 ('8') with ANODE=8'hFE; digit7 shows 7'h79 ('1') with ANODE=8'h7F; each digit is lit for 4 cycles after 1 blank cycle.
REQ-027 SHALL verify: FRAME_DONE pulses exactly once every 40 cycles, aligned to the last ON cycle of digit 7.
REQ-028 SHALL verify: HEX_IN changes from 32'hAAAAAAAA to 32'h55555555 during digit 3 -> the rest of the frame shows 'A' (7'h08) and the next frame shows '5' (7'h12).
REQ-029 SHALL verify: BLANK_LZ=1, HEX_IN=32'h000000F0 -> digits 2..7 have ANODE high throughout, digit1 shows 7'h0E, digit0 shows 7'h40. With HEX_IN=0, only digit0 lights.
REQ-030 SHALL verify: DP_IN=8'h01 -> DP=0 only during digit0 ON; DP=1 during every BLANK cycle.
REQ-031 SHALL verify: RESETn pulled low for 1 cycle during digit 5 ON -> the next edge gives ANODE=8'hFF and all outputs at reset values; the scan restarts at digit 0.
